dot_product_acc: RTL and testbench

//  Upstream stage of the ReLU activation block: computes one neuron pre-activation, sum(a[i]*b[i]) + bias, over VEC_LEN operand pairs.
//  - Operands are streamed with a valid/ready handshake.
//  - The result is requantised by an arithmetic right shift, saturated to WIDTH bits, and held on a valid/ready output for the activation stage.

---
 rtl/dot_product_acc.sv | 153 +++++++++++++++
 tb/tb_dot_product_acc.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_acc.sv
// dot_product_acc: neuron pre-activation stage feeding the ReLU activation block.
//   Accumulates sum(a[i]*b[i]) over VEC_LEN operand pairs, adds a bias, applies an
//   arithmetic right shift by SHIFT, saturates the result to WIDTH bits and holds it
//   on a valid/ready output.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   init       start pulse, only honoured while idle
//   ready      high while idle (init will be accepted)
//   bias       signed bias, captured with an accepted init
//   in_valid   operand pair valid
//   in_ready   high while accumulating; a pair is taken on in_valid & in_ready
//   in_a/in_b  signed operands, held by the producer until taken
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out_data   signed saturated result, keeps its value after the handshake
//
// Build option: define DOT_ROUND_EN to round half up (add 2^(SHIFT-1) before the
// shift) instead of flooring. Interface, latency and saturation are unchanged.

module dot_product_acc #(
    parameter int WIDTH     = 32,
    parameter int IN_WIDTH  = 16,
    parameter int VEC_LEN   = 64,
    parameter int ACC_WIDTH = 48,
    parameter int SHIFT     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        init,
    output logic                        ready,
    input  logic signed [WIDTH-1:0]     bias,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_a,
    input  logic signed [IN_WIDTH-1:0]  in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH-1:0]     out_data
);

    localparam int CntW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    // Two spare bits so acc + bias + rounding increment can never wrap.
    localparam int SumW = ACC_WIDTH + 2;
    localparam logic [CntW-1:0] LastCnt = CntW'(VEC_LEN - 1);

    localparam logic signed [SumW-1:0] MaxV =
        {{(SumW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [SumW-1:0] MinV =
        {{(SumW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

`ifdef DOT_ROUND_EN
    localparam logic signed [SumW-1:0] RoundInc =
        (SHIFT > 0) ? (SumW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
    localparam logic signed [SumW-1:0] RoundInc = '0;
`endif

    if (VEC_LEN < 1) begin : g_chk_len
        $error("dot_product_acc: VEC_LEN must be >= 1");
    end
    if (ACC_WIDTH < 2 * IN_WIDTH + $clog2(VEC_LEN) + 1 || ACC_WIDTH < WIDTH) begin : g_chk_acc
        $error("dot_product_acc: ACC_WIDTH too small for worst-case accumulation");
    end
    if (SHIFT < 0 || SHIFT >= ACC_WIDTH) begin : g_chk_shift
        $error("dot_product_acc: SHIFT out of range 0..ACC_WIDTH-1");
    end

    typedef enum logic [1:0] {StIdle, StAccum, StFinal, StOut} state_t;

    state_t                       state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic        [CntW-1:0]       cnt_q, cnt_d;
    logic signed [WIDTH-1:0]      bias_q, bias_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0]      out_data_q, out_data_d;

    logic signed [2*IN_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [SumW-1:0]       sum;
    logic signed [SumW-1:0]       res;
    logic signed [WIDTH-1:0]      sat;

    assign prod     = in_a * in_b;
    assign prod_ext = ACC_WIDTH'(prod);
    assign sum      = SumW'(acc_q) + SumW'(bias_q) + RoundInc;
    assign res      = sum >>> SHIFT;
    assign sat      = (res > MaxV) ? MaxV[WIDTH-1:0] :
                      (res < MinV) ? MinV[WIDTH-1:0] : res[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bias_d      = bias_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            StIdle: begin
                if (init) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    bias_d  = bias;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (in_valid) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) state_d = StFinal;
                end
            end
            StFinal: begin
                out_data_d  = sat;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            bias_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bias_q      <= bias_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign ready     = (state_q == StIdle);
    assign in_ready  = (state_q == StAccum);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_dot_product_acc.sv
// tb_dot_product_acc: two instances driven in lockstep (SHIFT=0 and SHIFT=2,
// VEC_LEN=4), each result compared against a plain-arithmetic dot-product model.

module tb_dot_product_acc;

    localparam int W  = 32;
    localparam int IW = 16;
    localparam int VL = 4;
    localparam int AW = 48;

    logic clk = 1'b0;
    logic reset, init, in_valid, out_ready;
    logic signed [W-1:0]  bias;
    logic signed [IW-1:0] in_a, in_b;
    logic ready0, in_ready0, out_valid0;
    logic ready2, in_ready2, out_valid2;
    logic signed [W-1:0] out_data0, out_data2;

    int vectors = 0;
    int errors  = 0;
    int va[VL];
    int vb[VL];

    always #5 clk = ~clk;

    dot_product_acc #(.WIDTH(W), .IN_WIDTH(IW), .VEC_LEN(VL), .ACC_WIDTH(AW), .SHIFT(0)) u_dut0 (
        .clk(clk), .reset(reset), .init(init), .ready(ready0), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0)
    );

    dot_product_acc #(.WIDTH(W), .IN_WIDTH(IW), .VEC_LEN(VL), .ACC_WIDTH(AW), .SHIFT(2)) u_dut2 (
        .clk(clk), .reset(reset), .init(init), .ready(ready2), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2)
    );

    // Reference: exact dot product plus bias, optional round-half-up, floor shift, clamp.
    function automatic longint model(input int shift, input longint bias_v);
        longint s;
        s = bias_v;
        for (int i = 0; i < VL; i++) s += longint'(va[i]) * longint'(vb[i]);
`ifdef DOT_ROUND_EN
        if (shift > 0) s += longint'(1) << (shift - 1);
`endif
        s = s >>> shift;
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s;
    endfunction

    function automatic logic [W-1:0] exp_w(input longint v);
        return v[W-1:0];
    endfunction

    // Drives one full operation; returns just after the edge that raises out_valid.
    task automatic run(input int bias_v, input bit bubbles,
                       output logic [W-1:0] d0, output logic [W-1:0] d2,
                       output bit to, output bit lat_ok);
        int n;
        int k;
        bit tog;
        n = 0;
        @(negedge clk);
        while (!ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        init = 1'b1;
        bias = bias_v;
        @(negedge clk);
        init = 1'b0;
        k = 0;
        n = 0;
        tog = 1'b0;
        while (k < VL && n < 200) begin
            in_a     = IW'(va[k]);
            in_b     = IW'(vb[k]);
            in_valid = bubbles ? tog : 1'b1;
            tog      = ~tog;
            if (in_valid && in_ready0) k++;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        to     = (k < VL);
        lat_ok = (out_valid0 == 1'b0);
        @(posedge clk);
        #1;
        lat_ok = lat_ok && (out_valid0 == 1'b1) && (out_valid2 == 1'b1);
        d0 = out_data0;
        d2 = out_data2;
    endtask

    task automatic set_spec_vec();
        va = '{1, 2, 3, 4};
        vb = '{5, 6, 7, 8};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        vectors++;
        if (ready0 !== 1'b1 || in_ready0 !== 1'b0 || out_valid0 !== 1'b0 || out_data0 !== '0) begin
            errors++;
            $display("FAIL reset_dut0: ready=%b in_ready=%b out_valid=%b out_data=%0d want 1 0 0 0",
                     ready0, in_ready0, out_valid0, out_data0);
        end
        vectors++;
        if (ready2 !== 1'b1 || in_ready2 !== 1'b0 || out_valid2 !== 1'b0 || out_data2 !== '0) begin
            errors++;
            $display("FAIL reset_dut2: ready=%b in_ready=%b out_valid=%b out_data=%0d want 1 0 0 0",
                     ready2, in_ready2, out_valid2, out_data2);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] d0, d2;
        bit to, lat;
        set_spec_vec();
        out_ready = 1'b1;
        run(10, 1'b0, d0, d2, to, lat);
        vectors++;
        if (to || !lat) begin
            errors++;
            $display("FAIL basic_latency: timeout=%0b latency_ok=%0b want 0 1", to, lat);
        end
        vectors++;
        if (d0 !== 32'd80) begin
            errors++;
            $display("FAIL basic_shift0: got %0d want 80", $signed(d0));
        end
        vectors++;
        if (d2 !== exp_w(model(2, 10))) begin
            errors++;
            $display("FAIL basic_shift2: got %0d want %0d", $signed(d2), model(2, 10));
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] d0, d2;
        bit to, lat;
        va = '{32767, 32767, 32767, 32767};
        vb = '{32767, 32767, 32767, 32767};
        run(0, 1'b0, d0, d2, to, lat);
        vectors++;
        if (to || d0 !== 32'h7fff_ffff) begin
            errors++;
            $display("FAIL sat_pos: got %0d want 2147483647 (timeout=%0b)", $signed(d0), to);
        end
        vectors++;
        if (d2 !== exp_w(model(2, 0))) begin
            errors++;
            $display("FAIL sat_pos_shift2: got %0d want %0d", $signed(d2), model(2, 0));
        end
        va = '{-32768, -32768, -32768, -32768};
        run(0, 1'b0, d0, d2, to, lat);
        vectors++;
        if (to || d0 !== 32'h8000_0000) begin
            errors++;
            $display("FAIL sat_neg: got %0d want -2147483648 (timeout=%0b)", $signed(d0), to);
        end
        vectors++;
        if (d2 !== exp_w(model(2, 0))) begin
            errors++;
            $display("FAIL sat_neg_shift2: got %0d want %0d", $signed(d2), model(2, 0));
        end
    endtask

    task automatic test_bubbles();
        logic [W-1:0] d0, d2;
        bit to, lat;
        set_spec_vec();
        @(negedge clk);
        vectors++;
        if (in_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_idle: got %b want 0", in_ready0);
        end
        run(10, 1'b1, d0, d2, to, lat);
        vectors++;
        if (to || d0 !== 32'd80) begin
            errors++;
            $display("FAIL bubbles: got %0d want 80 (timeout=%0b)", $signed(d0), to);
        end
        vectors++;
        if (in_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_out: got %b want 0", in_ready0);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d0, d2;
        bit to, lat;
        set_spec_vec();
        out_ready = 1'b0;
        run(10, 1'b0, d0, d2, to, lat);
        for (int c = 0; c < 5; c++) begin
            init = (c == 2);
            @(posedge clk);
            #1;
            vectors++;
            if (out_data0 !== 32'd80 || out_valid0 !== 1'b1 || ready0 !== 1'b0) begin
                errors++;
                $display("FAIL hold_c%0d: data=%0d valid=%b ready=%b want 80 1 0",
                         c, out_data0, out_valid0, ready0);
            end
        end
        init = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (ready0 !== 1'b1 || out_valid0 !== 1'b0 || out_data0 !== 32'd80) begin
            errors++;
            $display("FAIL release: ready=%b valid=%b data=%0d want 1 0 80",
                     ready0, out_valid0, out_data0);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (ready0 !== 1'b1 || in_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL init_in_out_ignored: ready=%b in_ready=%b want 1 0", ready0, in_ready0);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d0, d2;
        bit to, lat;
        set_spec_vec();
        @(negedge clk);
        init = 1'b1;
        bias = 10;
        @(negedge clk);
        init = 1'b0;
        in_valid = 1'b1;
        in_a = IW'(va[0]);
        in_b = IW'(vb[0]);
        @(posedge clk);
        #1;
        in_a = IW'(va[1]);
        in_b = IW'(vb[1]);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        if (ready0 !== 1'b1 || in_ready0 !== 1'b0 || out_valid0 !== 1'b0 || out_data0 !== '0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b in_ready=%b valid=%b data=%0d want 1 0 0 0",
                     ready0, in_ready0, out_valid0, out_data0);
        end
        @(negedge clk);
        reset = 1'b0;
        run(10, 1'b0, d0, d2, to, lat);
        vectors++;
        if (to || d0 !== 32'd80) begin
            errors++;
            $display("FAIL after_reset: got %0d want 80 (timeout=%0b)", $signed(d0), to);
        end
    endtask

    task automatic test_round();
        logic [W-1:0] d0, d2;
        bit to, lat;
        int exp_p, exp_n;
`ifdef DOT_ROUND_EN
        exp_p = 2;
        exp_n = -1;
`else
        exp_p = 1;
        exp_n = -2;
`endif
        va = '{1, 0, 0, 0};
        vb = '{6, 0, 0, 0};
        run(0, 1'b0, d0, d2, to, lat);
        vectors++;
        if (to || d2 !== W'(exp_p) || d0 !== 32'd6) begin
            errors++;
            $display("FAIL round_pos: shift2=%0d shift0=%0d want %0d 6", $signed(d2), $signed(d0), exp_p);
        end
        va = '{0, 0, 0, 0};
        run(-6, 1'b0, d0, d2, to, lat);
        vectors++;
        if (to || d2 !== W'(exp_n) || d0 !== W'(-6)) begin
            errors++;
            $display("FAIL round_neg: shift2=%0d shift0=%0d want %0d -6", $signed(d2), $signed(d0), exp_n);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] d0, d2;
        bit to, lat;
        int bv;
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < VL; i++) begin
                va[i] = int'($urandom_range(65535)) - 32768;
                vb[i] = int'($urandom_range(65535)) - 32768;
            end
            bv = int'($urandom);
            run(bv, 1'($urandom_range(1)), d0, d2, to, lat);
            vectors++;
            if (to || !lat || d0 !== exp_w(model(0, longint'(bv)))) begin
                errors++;
                $display("FAIL random%0d_shift0: got %0d want %0d (timeout=%0b lat=%0b)",
                         r, $signed(d0), model(0, longint'(bv)), to, lat);
            end
            vectors++;
            if (d2 !== exp_w(model(2, longint'(bv)))) begin
                errors++;
                $display("FAIL random%0d_shift2: got %0d want %0d",
                         r, $signed(d2), model(2, longint'(bv)));
            end
        end
    endtask

    initial begin
        init      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bias      = '0;
        in_a      = '0;
        in_b      = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_bubbles();
        test_backpressure();
        test_reset_mid();
        test_round();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
